fifo_count: RTL and testbench
=============================

Name: fifo_count

Overview:
- Parametrised successor to the team's valid/ready FIFO.
- Power-of-two depth with all entries usable, via wrap-bit pointers.
- Adds occupancy count, programmable almost-full/almost-empty flags, and a synchronous flush.
- Sits between producer and consumer stages (e.g. systolic-array feeders and drains) where back-pressure must be anticipated before full/empty.

Parameters:
width_p, 8, data word width in bits (>=1)
depth_p, 128, number of entries; power of two, >=2
almost_full_p, 120, almost_full_o asserts when count >= this value; legal range 1..depth_p
almost_empty_p, 8, almost_empty_o asserts when count <= this value; legal range 0..depth_p-1

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
flush_i  input  1  synchronous discard of all contents
ready_o  output  1  FIFO can accept a word (not full)
valid_i  input  1  producer presents data_i
data_i  input  width_p  write data
valid_o  output  1  FIFO holds at least one word
yumi_i  input  1  consumer takes data_o this cycle
data_o  output  width_p  head-of-queue word
count_o  output  $clog2(depth_p)+1  current occupancy, 0..depth_p
almost_full_o  output  1  count_o >= almost_full_p
almost_empty_o  output  1  count_o <= almost_empty_p
overflow_o  output  1  sticky write-while-full error (see Optional Feature)
underflow_o  output  1  sticky read-while-empty error (see Optional Feature)

Behaviour:
Interface:
- Clock is clk_i; reset is reset_i, synchronous and active-high. One clock domain.

Storage and pointers:
- Internal register array of depth_p x width_p, written synchronously, read asynchronously.
- rd_ptr and wr_ptr are each $clog2(depth_p)+1 bits (MSB is the wrap bit).
- empty = pointers equal.
- full = low bits equal and wrap bits differ.
- count = wr_ptr - rd_ptr, modulo 2^($clog2(depth_p)+1). Registered or derived, but it must match that value every cycle.

Handshakes:
- Write accepted iff valid_i & ready_o. Read accepted iff yumi_i & valid_o.
- ready_o = ~full and valid_o = ~empty, both from registered state only. Neither depends combinationally on valid_i or yumi_i.
- data_o = entry at rd_ptr. Only meaningful while valid_o=1; X-free but don't-care when empty.
- yumi_i while valid_o=0 is ignored: no pointer movement.
- valid_i while ready_o=0 is ignored: no write and no memory corruption. The array write enable is gated by acceptance.

Latency:
- Word written at edge N is visible on data_o with valid_o=1 after edge N (1-cycle write-to-read latency).
- No combinational bypass.

Simultaneous events:
- Read and write in the same cycle with 0<count<depth_p: both pointers advance and count is unchanged.
- When full, ready_o=0, so a concurrent yumi_i does not enable a write.
- When empty, valid_o=0, so a concurrent write is not readable until the next cycle.

Wrap-around:
- Pointers increment modulo 2^($clog2(depth_p)+1). Order is preserved across any number of wraps.

Flush:
- flush_i=1 sets rd_ptr = wr_ptr = 0 at the next edge.
- Takes priority over any same-cycle write or read; the write is discarded and the read is a no-op.
- Array contents are not cleared.

Reset:
- reset_i=1 has priority over flush_i and all handshakes, including mid-burst or while full.
- Next-cycle outputs: ready_o=1, valid_o=0, count_o=0, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.

Flags:
- almost_full_o and almost_empty_o are pure compares on the current count; no hysteresis.

Optional Feature:
Macro FIFO_ERR_EN.

Defined:
- overflow_o sets at the edge after any cycle with valid_i & ~ready_o.
- underflow_o sets at the edge after any cycle with yumi_i & ~valid_o.
- Both are sticky until reset_i or flush_i.
- Flush in the same cycle as an error clears the flag (flush wins).

Not defined:
- overflow_o and underflow_o are tied to 0.
- No error-detection logic is synthesised.
- All other behaviour is identical.

Test Plan:
- Reset, then write 0x01..0x80 (depth_p=128) with yumi_i=0 -> ready_o drops right after the 128th accept, count_o=128, almost_full_o=1 from count 120; read all -> data_o order 0x01..0x80, valid_o=0 and count_o=0 at end.
- Continuous simultaneous valid_i/yumi_i for 1000 cycles at count=5 -> count_o stays 5; pointers wrap 7+ times; output sequence matches input delayed by 5 words.
- Full FIFO, hold valid_i=1 data_i=0xFF for 3 cycles -> no write, contents intact. With FIFO_ERR_EN, overflow_o=1 until flush; without it, overflow_o=0.
- Empty FIFO, yumi_i=1 -> rd_ptr unchanged, valid_o=0; write 0x3C next cycle -> valid_o=1 and data_o=0x3C one edge later.
- count_o=50 with flush_i=1 and a concurrent valid write of 0xAA -> next cycle count_o=0, valid_o=0, almost_empty_o=1; 0xAA is never output.
- Assert reset_i mid-burst at count_o=64 with valid_i and yumi_i both high -> next cycle all outputs at reset values; the first subsequent write reads back correctly.

Source files
------------

// File: rtl/fifo_count.sv
// +--------------------------------------------------------------------------+
// | Module      : fifo_count                                                 |
// | Description : Valid/ready FIFO with power-of-two depth, wrap-bit         |
// |               pointers, occupancy count, almost-full/almost-empty flags  |
// |               and synchronous flush. Defining FIFO_ERR_EN adds sticky    |
// |               overflow/underflow error flags.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fifo_count #(
    parameter int width_p        = 8,
    parameter int depth_p        = 128,
    parameter int almost_full_p  = 120,
    parameter int almost_empty_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    output logic                       ready_o,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       valid_o,
    input  logic                       yumi_i,
    output logic [width_p-1:0]         data_o,
    output logic [$clog2(depth_p):0]   count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int c_addr_w = $clog2(depth_p);
    localparam int c_ptr_w  = c_addr_w + 1;
    localparam logic [c_ptr_w-1:0] c_almost_full  = c_ptr_w'(almost_full_p);
    localparam logic [c_ptr_w-1:0] c_almost_empty = c_ptr_w'(almost_empty_p);

    logic [width_p-1:0] r_mem [depth_p];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;

    logic               w_empty;
    logic               w_full;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [c_ptr_w-1:0] w_count;

    // Wrap bit distinguishes full from empty when the address bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                     (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
    assign w_wr_en = valid_i & ~w_full;
    assign w_rd_en = yumi_i & ~w_empty;
    assign w_count = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
        end
    end

    // Storage is never cleared; reset and flush only discard the pending write.
    always_ff @(posedge clk_i) begin
        if (w_wr_en && !flush_i && !reset_i) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= data_i;
        end
    end

    assign ready_o        = ~w_full;
    assign valid_o        = ~w_empty;
    assign data_o         = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign count_o        = w_count;
    assign almost_full_o  = (w_count >= c_almost_full);
    assign almost_empty_o = (w_count <= c_almost_empty);

`ifdef FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (valid_i && w_full)  r_overflow  <= 1'b1;
            if (yumi_i  && w_empty) r_underflow <= 1'b1;
        end
    end

    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_count.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_count                                              |
// | Description : Directed self-checking bench for fifo_count (defaults).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_count;

`ifdef FIFO_ERR_EN
    localparam logic c_err = 1'b1;
`else
    localparam logic c_err = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       flush;
    logic       ready;
    logic       valid_in;
    logic [7:0] data_in;
    logic       valid_out;
    logic       yumi;
    logic [7:0] data_out;
    logic [7:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] q_model [$];

    fifo_count dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .flush_i        (flush),
        .ready_o        (ready),
        .valid_i        (valid_in),
        .data_i         (data_in),
        .valid_o        (valid_out),
        .yumi_i         (yumi),
        .data_o         (data_out),
        .count_o        (count),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .overflow_o     (overflow),
        .underflow_o    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_aempty"}, 32'(almost_empty), 32'd1);
        check({tag, "_afull"}, 32'(almost_full), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_unf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; data_in = 8'h00; yumi = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Fill 0x01..0x80 with no reads.
        for (int i = 1; i <= 128; i++) begin
            check("fill_ready", 32'(ready), 32'd1);
            valid_in = 1'b1; data_in = 8'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), 32'(i >= 120));
            check("fill_aempty", 32'(almost_empty), 32'(i <= 8));
        end
        check("full_ready", 32'(ready), 32'd0);
        check("full_valid", 32'(valid_out), 32'd1);

        // Writes while full are ignored.
        data_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ovf_count", 32'(count), 32'd128);
            check("ovf_flag", 32'(overflow), 32'(c_err));
        end
        valid_in = 1'b0;

        for (int i = 1; i <= 128; i++) begin
            check("drain_valid", 32'(valid_out), 32'd1);
            check("drain_data", 32'(data_out), 32'(i));
            yumi = 1'b1;
            tick();
            check("drain_count", 32'(count), 32'(128 - i));
        end
        yumi = 1'b0;
        check("empty_valid", 32'(valid_out), 32'd0);
        check("empty_ready", 32'(ready), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'(c_err));

        flush = 1'b1; tick(); flush = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Read while empty is ignored.
        yumi = 1'b1; tick(); yumi = 1'b0;
        check("unf_valid", 32'(valid_out), 32'd0);
        check("unf_count", 32'(count), 32'd0);
        check("unf_flag", 32'(underflow), 32'(c_err));
        valid_in = 1'b1; data_in = 8'h3C; tick(); valid_in = 1'b0;
        check("w3c_valid", 32'(valid_out), 32'd1);
        check("w3c_data", 32'(data_out), 32'h3C);
        check("w3c_count", 32'(count), 32'd1);
        yumi = 1'b1; tick(); yumi = 1'b0;
        check("r3c_count", 32'(count), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("unf_cleared", 32'(underflow), 32'd0);

        // Steady-state streaming at occupancy 5 across many pointer wraps.
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; data_in = 8'(8'hA0 + i);
            q_model.push_back(data_in);
            tick();
        end
        valid_in = 1'b0;
        check("stream_start_count", 32'(count), 32'd5);
        for (int k = 0; k < 1000; k++) begin
            check("stream_data", 32'(data_out), 32'(q_model[0]));
            valid_in = 1'b1; yumi = 1'b1; data_in = 8'((k * 7 + 3) & 8'hFF);
            q_model.push_back(data_in);
            void'(q_model.pop_front());
            tick();
            check("stream_count", 32'(count), 32'd5);
        end
        valid_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stream_tail", 32'(data_out), 32'(q_model[0]));
            void'(q_model.pop_front());
            yumi = 1'b1; tick();
        end
        yumi = 1'b0;
        check("stream_end_count", 32'(count), 32'd0);

        // Flush beats a concurrent write.
        for (int i = 0; i < 50; i++) begin
            valid_in = 1'b1; data_in = 8'(i); tick();
        end
        check("pre_flush_count", 32'(count), 32'd50);
        flush = 1'b1; data_in = 8'hAA; tick();
        flush = 1'b0; valid_in = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(valid_out), 32'd0);
        check("flush_aempty", 32'(almost_empty), 32'd1);
        valid_in = 1'b1; data_in = 8'h11; tick(); valid_in = 1'b0;
        check("post_flush_data", 32'(data_out), 32'h11);
        check("post_flush_count", 32'(count), 32'd1);

        // Reset mid-burst with both handshakes active.
        for (int i = 0; i < 63; i++) begin
            valid_in = 1'b1; data_in = 8'(i + 1); tick();
        end
        check("pre_rst_count", 32'(count), 32'd64);
        valid_in = 1'b1; yumi = 1'b1; rst = 1'b1; data_in = 8'h77; tick();
        rst = 1'b0; valid_in = 1'b0; yumi = 1'b0;
        check_reset_state("midrst");
        valid_in = 1'b1; data_in = 8'h5A; tick(); valid_in = 1'b0;
        check("post_rst_valid", 32'(valid_out), 32'd1);
        check("post_rst_data", 32'(data_out), 32'h5A);
        check("post_rst_count", 32'(count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
